phase_timer_bank: RTL and testbench
===================================

PHASE_TIMER_BANK -- requirements
Module: phase_timer_bank

Interface
REQ-001 Parameter NUM_CH, default 4: number of independent timer channels (1..16).
REQ-002 Parameter CNT_W, default 32: counter and duration width in bits.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-005 ch_active  input  NUM_CH  per-channel "phase lit" level, e.g. a raw LED state.
REQ-006 duration_flat  input  NUM_CH*CNT_W  per-channel duration in ticks; channel i occupies bits [i*CNT_W +: CNT_W].
REQ-007 pause  input  1  global hold (emergency or pedestrian override); freezes all running counts.
REQ-008 restart  input  NUM_CH  per-channel forced restart of the current phase.
REQ-009 done  output  NUM_CH  registered one-cycle terminal pulse per channel.
REQ-010 expired  output  NUM_CH  sticky flag: terminal count reached during the current active phase.
REQ-011 busy  output  NUM_CH  channel is in RUN or HOLD.
REQ-012 remaining_flat  output  NUM_CH*CNT_W  ticks left per channel, packed the same way as duration_flat.

Function
REQ-013 Each channel SHALL run its own FSM with states IDLE, RUN, HOLD and EXPIRED; channels SHALL NOT interact except through pause.
REQ-014 Entry is ch_active[i]=1 while the registered previous value is 0; on entry the channel SHALL clear cnt, latch the duration, and go to RUN (or to HOLD if pause=1).
REQ-015 A latched duration of 0 SHALL be treated as 1; a duration change mid-phase SHALL have no effect until the next entry or restart.
REQ-016 In RUN with pause=0, when cnt equals latched_dur-1 the channel SHALL pulse done[i] for exactly one cycle, set expired[i], and go to EXPIRED; otherwise cnt increments by 1.
REQ-017 Latency: with no pause, done[i] SHALL be high in the cycle following the dur-th rising edge after the entry edge (dur=1 gives done one cycle after entry).
REQ-018 RUN moves to HOLD when pause=1, and HOLD moves back to RUN when pause=0; cnt SHALL NOT change in HOLD, so each paused cycle delays done by exactly one cycle.
REQ-019 EXPIRED SHALL NOT pulse done again while ch_active stays high; done SHALL NOT repeat.
REQ-020 ch_active[i]=0 in any state SHALL force IDLE and clear expired[i]; cnt SHALL hold its value (glitch tolerant), and any later entry restarts the count from 0.
REQ-021 restart[i]=1 with ch_active[i]=1 SHALL act as an entry (clear cnt, relatch duration, clear expired); restart[i] with ch_active[i]=0 SHALL be ignored.
REQ-022 Simultaneous events: restart in the same cycle as terminal count results in restart and no done; deassert in the terminal cycle results in IDLE and no done; pause in the terminal cycle results in HOLD and no done until pause=0.
REQ-023 remaining[i] SHALL be latched_dur-1-cnt in RUN or HOLD, and 0 in IDLE or EXPIRED; it SHALL be combinational from registered state and SHALL never underflow.
REQ-024 busy[i] SHALL be 1 in RUN or HOLD only.

Reset
REQ-025 While reset_n=0, all channels SHALL be IDLE, and cnt, latched duration, prev_active, done, expired and busy SHALL be 0.
REQ-026 An ch_active[i] held high across reset release SHALL be treated as an entry on the first active clock edge.
REQ-027 Reset asserted mid-phase SHALL abort the phase with no done pulse.

Structure
REQ-028 FSM state encodings and default NUM_CH/CNT_W constants SHALL live in the shared traffic controller package or header.
REQ-029 Per-channel logic SHALL be one sub-module, phase_timer_ch, instantiated NUM_CH times by a generate loop; the top level does only packing and unpacking.

Verification
REQ-030 Test: ch0 duration 5, active rises at edge E, held -> done[0] high only in the cycle after edge E+5, expired[0]=1 afterwards, no second done.
REQ-031 Test: duration 10, pause high for 3 cycles mid-count -> done delayed by exactly 3 cycles; remaining frozen during the pause.
REQ-032 Test: duration 0 and duration 1 -> both give done one cycle after entry.
REQ-033 Test: restart[1] in the terminal cycle of ch1 (duration 4) -> no done, then done 4 cycles later.
REQ-034 Test: 4 channels, durations 3/7/2/9, entries staggered -> each done at its own time; a duration change mid-phase is ignored.
REQ-035 Test: reset_n pulsed low mid-phase with active held high -> outputs 0, no done, and the count restarts from 0 after release.

Source files
------------

// File: rtl/phase_timer_bank_pkg.sv
// Shared constants and channel FSM encoding for the phase timer bank.
package phase_timer_bank_pkg;
  localparam int NUM_CH_DEF = 4;
  localparam int CNT_W_DEF  = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_HOLD    = 2'd2,
    ST_EXPIRED = 2'd3
  } ch_state_e;
endpackage

// File: rtl/phase_timer_bank_if.sv
// Control/status bundle between a traffic controller and the phase timer bank.
interface phase_timer_bank_if import phase_timer_bank_pkg::*; #(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int CNT_W  = CNT_W_DEF
);
  logic [NUM_CH-1:0]       ch_active;
  logic [NUM_CH*CNT_W-1:0] duration_flat;
  logic                    pause;
  logic [NUM_CH-1:0]       restart;
  logic [NUM_CH-1:0]       done;
  logic [NUM_CH-1:0]       expired;
  logic [NUM_CH-1:0]       busy;
  logic [NUM_CH*CNT_W-1:0] remaining_flat;

  modport master (
    output ch_active, duration_flat, pause, restart,
    input  done, expired, busy, remaining_flat
  );
  modport slave (
    input  ch_active, duration_flat, pause, restart,
    output done, expired, busy, remaining_flat
  );
endinterface

// File: rtl/phase_timer_ch.sv
// One phase timer channel: edge-triggered entry, pausable count, one-shot done.
module phase_timer_ch import phase_timer_bank_pkg::*; #(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_active,
  input  logic [CNT_W-1:0] i_dur,
  input  logic             i_pause,
  input  logic             i_restart,
  output logic             o_done,
  output logic             o_expired,
  output logic             o_busy,
  output logic [CNT_W-1:0] o_remaining
);
  ch_state_e        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_dur;
  logic             r_prev_active;
  logic             r_done;
  logic             r_expired;

  logic             w_entry;
  logic             w_terminal;
  logic [CNT_W-1:0] w_dur_lat;

  assign w_entry    = i_active & (~r_prev_active | i_restart);
  assign w_terminal = (r_cnt == r_dur - CNT_W'(1));
  assign w_dur_lat  = (i_dur == '0) ? CNT_W'(1) : i_dur;

  // HOLD resumes with a live count step on the first unpaused cycle, so each
  // paused cycle costs exactly one cycle of delay.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_dur         <= '0;
      r_prev_active <= 1'b0;
      r_done        <= 1'b0;
      r_expired     <= 1'b0;
    end else begin
      r_prev_active <= i_active;
      r_done        <= 1'b0;
      if (!i_active) begin
        r_state   <= ST_IDLE;
        r_expired <= 1'b0;
      end else if (w_entry) begin
        r_cnt     <= '0;
        r_dur     <= w_dur_lat;
        r_expired <= 1'b0;
        r_state   <= i_pause ? ST_HOLD : ST_RUN;
      end else begin
        case (r_state)
          ST_RUN, ST_HOLD: begin
            if (i_pause) begin
              r_state <= ST_HOLD;
            end else if (w_terminal) begin
              r_state   <= ST_EXPIRED;
              r_done    <= 1'b1;
              r_expired <= 1'b1;
            end else begin
              r_state <= ST_RUN;
              r_cnt   <= r_cnt + CNT_W'(1);
            end
          end
          default: r_state <= r_state;
        endcase
      end
    end
  end

  assign o_done      = r_done;
  assign o_expired   = r_expired;
  assign o_busy      = (r_state == ST_RUN) || (r_state == ST_HOLD);
  assign o_remaining = o_busy ? (r_dur - CNT_W'(1) - r_cnt) : '0;
endmodule

// File: rtl/phase_timer_bank.sv
// Bank of independent phase timers; top level only fans the bus out to channels.
module phase_timer_bank import phase_timer_bank_pkg::*; #(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input logic               clk,
  input logic               reset_n,
  phase_timer_bank_if.slave bus
);
  logic [NUM_CH-1:0][CNT_W-1:0] w_dur;
  logic [NUM_CH-1:0][CNT_W-1:0] w_rem;
  logic [NUM_CH-1:0]            w_done;
  logic [NUM_CH-1:0]            w_expired;
  logic [NUM_CH-1:0]            w_busy;

  assign w_dur = bus.duration_flat;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    phase_timer_ch #(.CNT_W(CNT_W)) u_ch (
      .clk         (clk),
      .reset_n     (reset_n),
      .i_active    (bus.ch_active[g]),
      .i_dur       (w_dur[g]),
      .i_pause     (bus.pause),
      .i_restart   (bus.restart[g]),
      .o_done      (w_done[g]),
      .o_expired   (w_expired[g]),
      .o_busy      (w_busy[g]),
      .o_remaining (w_rem[g])
    );
  end

  assign bus.done           = w_done;
  assign bus.expired        = w_expired;
  assign bus.busy           = w_busy;
  assign bus.remaining_flat = w_rem;
endmodule

// File: tb/tb_phase_timer_bank.sv
// Directed self-checking bench for phase_timer_bank.
module tb_phase_timer_bank;
  localparam int NCH = 4;
  localparam int CW  = 32;

  logic clk = 1'b0;
  logic reset_n;
  int   npass = 0;
  int   ntot  = 0;
  int   exp_t [NCH] = '{3, 8, 4, 12};

  phase_timer_bank_if #(.NUM_CH(NCH), .CNT_W(CW)) bus ();

  phase_timer_bank #(.NUM_CH(NCH), .CNT_W(CW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  function automatic logic [31:0] rem(input int c);
    return bus.remaining_flat[c*CW +: CW];
  endfunction

  task automatic set_dur(input int c, input logic [31:0] d);
    bus.duration_flat[c*CW +: CW] = d;
  endtask

  initial begin
    reset_n           = 1'b0;
    bus.ch_active     = '0;
    bus.duration_flat = '0;
    bus.pause         = 1'b0;
    bus.restart       = '0;
    tick(2);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_expired", 32'(bus.expired), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    for (int c = 0; c < NCH; c++) chk($sformatf("rst_rem%0d", c), rem(c), 0);
    reset_n = 1'b1;
    tick();

    // basic duration 5 on ch0
    set_dur(0, 5);
    bus.ch_active[0] = 1'b1;
    tick();
    chk("d5_busy", 32'(bus.busy[0]), 1);
    chk("d5_rem0", rem(0), 4);
    chk("d5_done0", 32'(bus.done[0]), 0);
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk($sformatf("d5_done_k%0d", k), 32'(bus.done[0]), 0);
      chk($sformatf("d5_rem_k%0d", k), rem(0), 32'(4 - k));
    end
    tick();
    chk("d5_done", 32'(bus.done[0]), 1);
    chk("d5_expired", 32'(bus.expired[0]), 1);
    chk("d5_busy_end", 32'(bus.busy[0]), 0);
    chk("d5_rem_end", rem(0), 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("d5_nodone_%0d", k), 32'(bus.done[0]), 0);
      chk($sformatf("d5_sticky_%0d", k), 32'(bus.expired[0]), 1);
    end
    bus.ch_active[0] = 1'b0;
    tick();
    chk("d5_exp_clr", 32'(bus.expired[0]), 0);

    // duration 10 with a 3-cycle pause after two counts
    set_dur(0, 10);
    bus.ch_active[0] = 1'b1;
    tick();
    chk("p_rem_entry", rem(0), 9);
    tick(2);
    chk("p_rem_pre", rem(0), 7);
    bus.pause = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("p_rem_frozen%0d", k), rem(0), 7);
      chk($sformatf("p_busy%0d", k), 32'(bus.busy[0]), 1);
    end
    bus.pause = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      tick();
      chk($sformatf("p_done_k%0d", k), 32'(bus.done[0]), 0);
      chk($sformatf("p_rem_k%0d", k), rem(0), 32'(7 - k));
    end
    tick();
    chk("p_done", 32'(bus.done[0]), 1);
    bus.ch_active[0] = 1'b0;
    tick();

    // durations 0 and 1 both finish one cycle after entry
    for (int d = 0; d < 2; d++) begin
      set_dur(0, 32'(d));
      bus.ch_active[0] = 1'b1;
      tick();
      chk($sformatf("d%0d_rem", d), rem(0), 0);
      chk($sformatf("d%0d_busy", d), 32'(bus.busy[0]), 1);
      chk($sformatf("d%0d_early", d), 32'(bus.done[0]), 0);
      tick();
      chk($sformatf("d%0d_done", d), 32'(bus.done[0]), 1);
      bus.ch_active[0] = 1'b0;
      tick();
    end

    // restart in the terminal cycle of ch1
    set_dur(1, 4);
    bus.ch_active[1] = 1'b1;
    tick();
    tick(3);
    chk("rs_rem_pre", rem(1), 0);
    bus.restart[1] = 1'b1;
    tick();
    bus.restart[1] = 1'b0;
    chk("rs_nodone", 32'(bus.done[1]), 0);
    chk("rs_rem", rem(1), 3);
    chk("rs_busy", 32'(bus.busy[1]), 1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("rs_wait%0d", k), 32'(bus.done[1]), 0);
    end
    tick();
    chk("rs_done", 32'(bus.done[1]), 1);
    bus.ch_active[1] = 1'b0;
    tick();

    // pause and deassert landing on the terminal cycle
    set_dur(3, 2);
    bus.ch_active[3] = 1'b1;
    tick(2);
    bus.pause = 1'b1;
    tick();
    chk("tp_nodone", 32'(bus.done[3]), 0);
    chk("tp_busy", 32'(bus.busy[3]), 1);
    bus.pause = 1'b0;
    tick();
    chk("tp_done", 32'(bus.done[3]), 1);
    bus.ch_active[3] = 1'b0;
    tick();
    bus.ch_active[3] = 1'b1;
    tick(2);
    bus.ch_active[3] = 1'b0;
    tick();
    chk("td_nodone", 32'(bus.done[3]), 0);
    chk("td_busy", 32'(bus.busy[3]), 0);
    chk("td_expired", 32'(bus.expired[3]), 0);

    // four channels, staggered entries, mid-phase duration edits ignored
    set_dur(0, 3); set_dur(1, 7); set_dur(2, 2); set_dur(3, 9);
    for (int t = 0; t < 15; t++) begin
      if (t < NCH) bus.ch_active[t] = 1'b1;
      if (t == 5) begin set_dur(3, 1); set_dur(1, 2); end
      tick();
      for (int c = 0; c < NCH; c++)
        chk($sformatf("stag_done%0d_t%0d", c, t), 32'(bus.done[c]), 32'(t == exp_t[c]));
    end
    bus.ch_active = '0;
    tick();

    // reset mid-phase with active held high
    set_dur(2, 6);
    bus.ch_active[2] = 1'b1;
    tick(3);
    chk("mr_busy_pre", 32'(bus.busy[2]), 1);
    reset_n = 1'b0;
    #1;
    chk("mr_busy", 32'(bus.busy[2]), 0);
    chk("mr_rem", rem(2), 0);
    chk("mr_done", 32'(bus.done[2]), 0);
    tick(2);
    chk("mr_done_hold", 32'(bus.done[2]), 0);
    chk("mr_exp_hold", 32'(bus.expired[2]), 0);
    reset_n = 1'b1;
    tick();
    chk("mr_rem_entry", rem(2), 5);
    chk("mr_busy_entry", 32'(bus.busy[2]), 1);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("mr_wait%0d", k), 32'(bus.done[2]), 0);
    end
    tick();
    chk("mr_done_final", 32'(bus.done[2]), 1);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
